// File: rtl/lock_input_conditioner.sv
// Synchronises and debounces raw KEY/SW, emits one-cycle press/release pulses per key and
// captures the debounced switch code on each confirmed enter press.
module lock_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 3,
  parameter int unsigned CNT_W           = 2
) (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic [1:0] KEY,
  input  logic [3:0] SW,
  output logic [1:0] key_level,
  output logic [1:0] key_press,
  output logic [1:0] key_release,
  output logic [3:0] sw_level,
  output logic       code_strobe,
  output logic [3:0] code_value
);

  localparam int unsigned NumIn = 6;
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [NumIn-1:0] raw;
  logic [NumIn-1:0] s1_q, s2_q;
  logic [NumIn-1:0] level_q, level_d;
  logic [CNT_W-1:0] cnt_q [NumIn];
  logic [CNT_W-1:0] cnt_d [NumIn];
  logic [1:0]       key_rise, key_fall;
  logic [1:0]       key_press_q, key_release_q;
  logic             code_strobe_q;
  logic [3:0]       code_value_q;

  assign raw = {SW, KEY};

  // Counter clears whenever the synced input agrees with the level, so it never wraps.
  always_comb begin
    for (int i = 0; i < NumIn; i++) begin
      level_d[i] = level_q[i];
      cnt_d[i]   = '0;
      if (s2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          level_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntOne;
        end
      end
    end
  end

  assign key_rise = level_d[1:0] & ~level_q[1:0];
  assign key_fall = ~level_d[1:0] & level_q[1:0];

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      s1_q          <= '0;
      s2_q          <= '0;
      level_q       <= '0;
      cnt_q         <= '{default: '0};
      key_press_q   <= '0;
      key_release_q <= '0;
      code_strobe_q <= 1'b0;
      code_value_q  <= '0;
    end else begin
      s1_q          <= raw;
      s2_q          <= s1_q;
      level_q       <= level_d;
      cnt_q         <= cnt_d;
      key_press_q   <= key_rise;
      key_release_q <= key_fall;
      code_strobe_q <= key_rise[1];
      // Capture the switch level as it stood before the enter edge.
      if (key_rise[1]) begin
        code_value_q <= level_q[5:2];
      end
    end
  end

  assign key_level   = level_q[1:0];
  assign sw_level    = level_q[5:2];
  assign key_press   = key_press_q;
  assign key_release = key_release_q;
  assign code_strobe = code_strobe_q;
  assign code_value  = code_value_q;

endmodule

// File: tb/tb_lock_input_conditioner.sv
// Scoreboard bench for lock_input_conditioner: expectations are queued with their due cycle when
// stimulus is driven, and pulses are checked every cycle against the queued set.
module tb_lock_input_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] key;
  logic [3:0] sw;
  logic [1:0] key_level, key_press, key_release;
  logic [3:0] sw_level;
  logic       code_strobe;
  logic [3:0] code_value;

  lock_input_conditioner #(
    .DEBOUNCE_CYCLES(3),
    .CNT_W          (2)
  ) dut (
    .CLOCK_50   (clk),
    .rst        (rst),
    .KEY        (key),
    .SW         (sw),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .sw_level   (sw_level),
    .code_strobe(code_strobe),
    .code_value (code_value)
  );

  always #5 clk = ~clk;

  localparam int SelPulse = 0;
  localparam int SelKey   = 1;
  localparam int SelSw    = 2;
  localparam int SelCode  = 3;

  // Pulse vector: {press[1], press[0], release[1], release[0], strobe}
  localparam logic [4:0] PEnter  = 5'b10001;
  localparam logic [4:0] PBoth   = 5'b11001;
  localparam logic [4:0] PClear  = 5'b01000;
  localparam logic [4:0] REnter  = 5'b00100;
  localparam logic [4:0] RBoth   = 5'b00110;
  localparam logic [4:0] RClear  = 5'b00010;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   cycle = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h, want %0h", tag, cycle, obs, exp);
    end
  endtask

  task automatic expect_at(input int dly, input int sel, input logic [31:0] val, input string tag);
    exp_t e;
    e.cyc = cycle + dly;
    e.sel = sel;
    e.val = val;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic tick();
    logic [4:0] exp_p;
    @(posedge clk);
    #1;
    cycle++;
    exp_p = '0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cycle) begin
        case (sb[i].sel)
          SelPulse: exp_p = exp_p | sb[i].val[4:0];
          SelKey:   check(sb[i].tag, 32'(key_level), sb[i].val);
          SelSw:    check(sb[i].tag, 32'(sw_level), sb[i].val);
          default:  check(sb[i].tag, 32'(code_value), sb[i].val);
        endcase
        sb.delete(i);
      end
    end
    check("pulses", 32'({key_press, key_release, code_strobe}), 32'(exp_p));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1;
    key = 2'b00;
    sw  = 4'h0;

    // 1: reset, then quiet for 10 cycles
    ticks(2);
    check("rst_key_level", 32'(key_level), 32'd0);
    check("rst_sw_level", 32'(sw_level), 32'd0);
    check("rst_code_value", 32'(code_value), 32'd0);
    rst = 1'b0;
    ticks(10);

    // 2: enter press with SW=9
    sw = 4'h9;
    expect_at(4, SelSw, 32'h0, "sw_not_yet");
    expect_at(5, SelSw, 32'h9, "sw_9");
    ticks(6);
    key = 2'b10;
    expect_at(4, SelKey, 32'h0, "enter_not_yet");
    expect_at(5, SelPulse, 32'(PEnter), "");
    expect_at(5, SelKey, 32'h2, "enter_level");
    expect_at(5, SelCode, 32'h9, "code_9");
    ticks(5);
    key = 2'b00;
    expect_at(5, SelPulse, 32'(REnter), "");
    expect_at(5, SelKey, 32'h0, "enter_released");
    ticks(8);

    // 3: two-cycle glitch on enter
    key = 2'b10;
    ticks(2);
    key = 2'b00;
    expect_at(10, SelKey, 32'h0, "glitch_level");
    expect_at(10, SelCode, 32'h9, "glitch_code_held");
    ticks(10);

    // 4: switch glitch rejected, then clean change
    sw = 4'h1;
    expect_at(5, SelSw, 32'h1, "sw_1");
    ticks(6);
    sw = 4'h0;
    for (int d = 1; d <= 8; d++) expect_at(d, SelSw, 32'h1, "sw_glitch_held");
    ticks(2);
    sw = 4'h1;
    ticks(6);
    sw = 4'h6;
    expect_at(4, SelSw, 32'h1, "sw_6_not_yet");
    expect_at(5, SelSw, 32'h6, "sw_6");
    ticks(6);

    // 5: both keys on the same edge
    key = 2'b11;
    expect_at(5, SelPulse, 32'(PBoth), "");
    expect_at(5, SelKey, 32'h3, "both_level");
    expect_at(5, SelCode, 32'h6, "code_6");
    ticks(6);
    key = 2'b00;
    expect_at(5, SelPulse, 32'(RBoth), "");
    ticks(8);

    // 6: clear held, reset pulsed mid-count
    key = 2'b01;
    ticks(3);
    rst = 1'b1;
    tick();
    check("midrst_key_level", 32'(key_level), 32'd0);
    check("midrst_code_value", 32'(code_value), 32'd0);
    rst = 1'b0;
    expect_at(4, SelKey, 32'h0, "clear_not_yet");
    expect_at(5, SelPulse, 32'(PClear), "");
    expect_at(5, SelKey, 32'h1, "clear_level");
    ticks(7);
    key = 2'b00;
    expect_at(5, SelPulse, 32'(RClear), "");
    ticks(8);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
